// File: rtl/sha256_block_padder.sv
// sha256_block_padder: reads a fixed-length message from a synchronous-read
// word memory, applies SHA-256 padding and hands complete 512-bit blocks to
// the compression core over a valid/ready handshake.
//
// Optional build macro: SHA256_PAD_BYTESWAP_EN
//   defined   -> every word read from memory is byte-reversed before it is
//                stored (little-endian message images); pad/length words are
//                never swapped.
//   undefined -> memory words pass through unchanged.
module sha256_block_padder #(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_read_data,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [511:0]      blk_data,
    output logic              blk_last,
    output logic [7:0]        blk_index,
    output logic              busy,
    output logic              done
);

    // Block count, global word index width and the fixed pad/length slots.
    localparam int unsigned NB       = (NUM_OF_WORDS + 18) / 16;
    localparam int unsigned G_W      = 12;
    localparam int unsigned GE_W     = G_W + 1;
    localparam int unsigned CNT_W    = 5;
    localparam logic [GE_W-1:0] MSG_LEN  = GE_W'(NUM_OF_WORDS);
    localparam logic [G_W-1:0]  PAD_SLOT = G_W'(NUM_OF_WORDS);
    localparam logic [G_W-1:0]  LEN_SLOT = G_W'(16 * NB - 1);
    localparam logic [31:0]     LEN_LO   = 32'(NUM_OF_WORDS * 32);
    localparam logic [31:0]     PAD_WORD = 32'h8000_0000;
    localparam logic [7:0]      LAST_BLK = 8'(NB - 1);
    localparam logic            FIRST_IS_MEM = (NUM_OF_WORDS != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        OFFER = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   msg_addr;
    logic [CNT_W-1:0]    cnt;
    logic                rd_pend;

    logic [G_W-1:0]      g_cur;
    logic [G_W-1:0]      g_nxt;
    logic [G_W-1:0]      g_blk0;
    logic                cur_is_mem;
    logic                nxt_issue;
    logic                blk0_issue;
    logic [3:0]          cur_slot;
    logic [3:0]          prev_slot;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    // True when global word index g refers to a message word in memory.
    function automatic logic is_msg(input logic [G_W-1:0] g);
        return (GE_W'(g) + GE_W'(1)) <= MSG_LEN;
    endfunction

    // Content of a non-memory slot: pad marker, length low word or zero.
    function automatic logic [31:0] pad_word(input logic [G_W-1:0] g);
        logic [31:0] w;
        w = 32'h0;
        if (g == PAD_SLOT) begin
            w = PAD_WORD;
        end else if (g == LEN_SLOT) begin
            w = LEN_LO;
        end
        return w;
    endfunction

`ifdef SHA256_PAD_BYTESWAP_EN
    // Little-endian images: reverse byte order of each memory word.
    function automatic logic [31:0] mem_word(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
`else
    // Big-endian images: memory words are used as-is.
    function automatic logic [31:0] mem_word(input logic [31:0] w);
        return w;
    endfunction
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus slot/address decode for the current load cycle.
    always_comb begin
        state_next = state;
        cur_slot   = cnt[3:0];
        prev_slot  = 4'(cnt - CNT_W'(1));
        g_cur      = {blk_index, cnt[3:0]};
        g_nxt      = {blk_index, 4'(cnt[3:0] + 4'd1)};
        g_blk0     = {8'(blk_index + 8'd1), 4'd0};
        cur_is_mem = (cnt < CNT_W'(16)) && is_msg(g_cur);
        nxt_issue  = (cnt < CNT_W'(15)) && is_msg(g_nxt);
        blk0_issue = is_msg(g_blk0);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cnt == CNT_W'(16)) begin
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (blk_ready) begin
                    state_next = blk_last ? FIN : LOAD;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered datapath: address issue, slot fill, handshake and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_valid <= 1'b0;
            blk_last  <= 1'b0;
            blk_index <= 8'd0;
            blk_data  <= 512'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_addr  <= '0;
            msg_addr  <= '0;
            cnt       <= '0;
            rd_pend   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        msg_addr  <= message_addr;
                        blk_index <= 8'd0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        rd_pend   <= 1'b0;
                        if (FIRST_IS_MEM) begin
                            mem_addr <= message_addr;
                        end
                    end
                end
                LOAD: begin
                    // Data for the slot addressed last cycle arrives now.
                    if (rd_pend) begin
                        blk_data[32 * (15 - int'(prev_slot)) +: 32] <= mem_word(mem_read_data);
                    end
                    if (cnt == CNT_W'(16)) begin
                        blk_valid <= 1'b1;
                        blk_last  <= (blk_index == LAST_BLK);
                        rd_pend   <= 1'b0;
                    end else begin
                        rd_pend <= cur_is_mem;
                        if (!cur_is_mem) begin
                            blk_data[32 * (15 - int'(cur_slot)) +: 32] <= pad_word(g_cur);
                        end
                        // Address is presented one cycle ahead of its slot.
                        if (nxt_issue) begin
                            mem_addr <= msg_addr + ADDR_W'(g_nxt);
                        end
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                OFFER: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        if (blk_last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            blk_index <= blk_index + 8'd1;
                            cnt       <= '0;
                            if (blk0_issue) begin
                                mem_addr <= msg_addr + ADDR_W'(g_blk0);
                            end
                        end
                    end
                end
                FIN: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
